id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the execute-stage ALU (3-bit op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- Registers decoded operands and control from ID, and forwards results from the EX/MEM and MEM/WB stages onto the ALU a/b inputs.
- Detects load-use hazards and inserts bubbles; honours pipeline-wide stall and flush.

---
 rtl/id_ex_stage_pkg.sv | 14 +
 rtl/id_ex_stage_fwd_mux.sv | 39 +++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU op encodings and forward-select codes.
package id_ex_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: picks EX/MEM, then MEM/WB, then the register-file value.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic [REGW-1:0]  i_src,
  input  logic [WIDTH-1:0] i_rf_val,
  input  logic             i_mem_regwrite,
  input  logic [REGW-1:0]  i_mem_writereg,
  input  logic [WIDTH-1:0] i_mem_aluout,
  input  logic             i_wb_regwrite,
  input  logic [REGW-1:0]  i_wb_writereg,
  input  logic [WIDTH-1:0] i_wb_result,
  output logic [WIDTH-1:0] o_val,
  output logic [1:0]       o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Register 0 is hardwired, so a write to it never supplies a forwarded value.
  assign w_mem_hit = i_mem_regwrite && (i_mem_writereg != '0) && (i_mem_writereg == i_src);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_writereg  != '0) && (i_wb_writereg  == i_src);

  always_comb begin
    o_val = i_rf_val;
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_val = i_mem_aluout;
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_val = i_wb_result;
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [REGW-1:0]  id_rd,
  input  logic [2:0]       id_alucontrol,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_regwrite,
  input  logic [REGW-1:0]  mem_writereg,
  input  logic [WIDTH-1:0] mem_aluout,
  input  logic             wb_regwrite,
  input  logic [REGW-1:0]  wb_writereg,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_writedata,
  output logic [REGW-1:0]  ex_writereg,
  output logic             ex_regwrite,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic [WIDTH-1:0] ex_pc,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             lu_stall
);

  logic             r_valid;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic [WIDTH-1:0] r_imm;
  logic [REGW-1:0]  r_rs;
  logic [REGW-1:0]  r_rt;
  logic [REGW-1:0]  r_writereg;
  logic [2:0]       r_op;
  logic             r_alusrc;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_memwrite;
  logic             r_branch;

  logic             w_bubble;
  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;

  // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
  assign lu_stall = r_valid && r_memtoreg && id_valid && (r_writereg != '0) &&
                    ((r_writereg == id_rs) || (r_writereg == id_rt));

  // Flush beats stall; an invalid ID slot is captured as a bubble too.
  assign w_bubble = flush || (!stall && (lu_stall || !id_valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_writereg <= '0;
      r_op       <= ALU_AND;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_writereg <= '0;
      r_op       <= ALU_AND;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
    end else if (!stall) begin
      r_valid    <= 1'b1;
      r_pc       <= id_pc;
      r_rd1      <= id_rd1;
      r_rd2      <= id_rd2;
      r_imm      <= id_imm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_writereg <= id_regdst ? id_rd : id_rt;
      r_op       <= id_alucontrol;
      r_alusrc   <= id_alusrc;
      r_regwrite <= id_regwrite;
      r_memtoreg <= id_memtoreg;
      r_memwrite <= id_memwrite;
      r_branch   <= id_branch;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_a (
    .i_src          (r_rs),
    .i_rf_val       (r_rd1),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_writereg (mem_writereg),
    .i_mem_aluout   (mem_aluout),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_writereg  (wb_writereg),
    .i_wb_result    (wb_result),
    .o_val          (w_fwd_rs),
    .o_sel          (fwd_a_sel)
  );

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_b (
    .i_src          (r_rt),
    .i_rf_val       (r_rd2),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_writereg (mem_writereg),
    .i_mem_aluout   (mem_aluout),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_writereg  (wb_writereg),
    .i_wb_result    (wb_result),
    .o_val          (w_fwd_rt),
    .o_sel          (fwd_b_sel)
  );

  assign alu_a        = w_fwd_rs;
  assign alu_b        = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_writedata = w_fwd_rt;
  assign alu_op       = r_op;
  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_writereg  = r_writereg;
  assign ex_regwrite  = r_valid & r_regwrite;
  assign ex_memtoreg  = r_valid & r_memtoreg;
  assign ex_memwrite  = r_valid & r_memwrite;
  assign ex_branch    = r_valid & r_branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding vector table plus load-use, stall, flush and reset sequences.
module tb_id_ex_stage;

  localparam int WIDTH = 32;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [REGW-1:0]  id_rs, id_rt, id_rd;
  logic [2:0]       id_alucontrol;
  logic             id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_branch;
  logic             stall, flush;
  logic             mem_regwrite;
  logic [REGW-1:0]  mem_writereg;
  logic [WIDTH-1:0] mem_aluout;
  logic             wb_regwrite;
  logic [REGW-1:0]  wb_writereg;
  logic [WIDTH-1:0] wb_result;
  logic [WIDTH-1:0] alu_a, alu_b, ex_writedata, ex_pc;
  logic [2:0]       alu_op;
  logic             ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch, lu_stall;
  logic [REGW-1:0]  ex_writereg;
  logic [1:0]       fwd_a_sel, fwd_b_sel;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alucontrol(id_alucontrol),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .stall(stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_pc(ex_pc), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .lu_stall(lu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  op;
    logic        alusrc, regdst;
    logic        mrw; logic [4:0] mwr; logic [31:0] mval;
    logic        wrw; logic [4:0] wwr; logic [31:0] wval;
    logic [31:0] exp_a, exp_b, exp_wd;
    logic [1:0]  exp_sa, exp_sb;
    logic [4:0]  exp_wr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                        input logic [31:0] rd1, rd2, imm, input logic [2:0] op,
                        input logic alusrc, regdst, regwrite, memtoreg, memwrite, branch);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alucontrol = op;
    id_alusrc = alusrc; id_regdst = regdst; id_regwrite = regwrite;
    id_memtoreg = memtoreg; id_memwrite = memwrite; id_branch = branch;
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] mwr, input logic [31:0] mval,
                         input logic wrw, input logic [4:0] wwr, input logic [31:0] wval);
    mem_regwrite = mrw; mem_writereg = mwr; mem_aluout = mval;
    wb_regwrite = wrw; wb_writereg = wwr; wb_result = wval;
  endtask

  initial begin
    // rs rt rd rd1 rd2 imm op alusrc regdst | mem | wb | exp a, b, wd, sel a, sel b, writereg
    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                32'd5, 32'd7, 32'd7, 2'b00, 2'b00, 5'd3};
    vecs[1] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 1'b1,
                1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20,
                32'h10, 32'd7, 32'd7, 2'b10, 2'b00, 5'd3};
    vecs[2] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 1'b1,
                1'b0, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20,
                32'h20, 32'd7, 32'd7, 2'b01, 2'b00, 5'd3};
    vecs[3] = '{5'd0, 5'd2, 5'd3, 32'h55, 32'd7, 32'd0, 3'b001, 1'b0, 1'b1,
                1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0,
                32'h55, 32'd7, 32'd7, 2'b00, 2'b00, 5'd3};
    vecs[4] = '{5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0,
                1'b1, 5'd2, 32'h33, 1'b0, 5'd0, 32'h0,
                32'd5, 32'hFFFF_FFFC, 32'h33, 2'b00, 2'b10, 5'd2};
    vecs[5] = '{5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 3'b111, 1'b0, 1'b1,
                1'b1, 5'd6, 32'h1234, 1'b1, 5'd7, 32'hABCD,
                32'h1234, 32'hABCD, 32'hABCD, 2'b10, 2'b01, 5'd8};
    vecs[6] = '{5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 32'd0, 3'b000, 1'b0, 1'b1,
                1'b0, 5'd6, 32'h1234, 1'b0, 5'd7, 32'hABCD,
                32'd1, 32'd2, 32'd2, 2'b00, 2'b00, 5'd8};
    vecs[7] = '{5'd3, 5'd0, 5'd4, 32'd9, 32'h77, 32'd0, 3'b110, 1'b0, 1'b1,
                1'b1, 5'd3, 32'h5A, 1'b1, 5'd0, 32'hDEAD,
                32'h5A, 32'h77, 32'h77, 2'b10, 2'b00, 5'd4};

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);
    step(); step();
    rst = 1'b1;
    #1;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_op", {29'd0, alu_op}, 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    chk("reset_regwrite", {31'd0, ex_regwrite}, 32'd0);
    chk("reset_writereg", {27'd0, ex_writereg}, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);

    for (int i = 0; i < 8; i++) begin
      set_id(1'b1, 32'h1000 + 32'(i) * 4, vecs[i].rs, vecs[i].rt, vecs[i].rd,
             vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].op,
             vecs[i].alusrc, vecs[i].regdst, 1'b1, 1'b0, 1'b0, 1'b0);
      set_fwd(vecs[i].mrw, vecs[i].mwr, vecs[i].mval, vecs[i].wrw, vecs[i].wwr, vecs[i].wval);
      step();
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
      chk($sformatf("v%0d_wdata", i), ex_writedata, vecs[i].exp_wd);
      chk($sformatf("v%0d_sel_a", i), {30'd0, fwd_a_sel}, {30'd0, vecs[i].exp_sa});
      chk($sformatf("v%0d_sel_b", i), {30'd0, fwd_b_sel}, {30'd0, vecs[i].exp_sb});
      chk($sformatf("v%0d_wreg", i), {27'd0, ex_writereg}, {27'd0, vecs[i].exp_wr});
      chk($sformatf("v%0d_op", i), {29'd0, alu_op}, {29'd0, vecs[i].op});
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
    end
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // Load-use: lw $4 in EX, sub $6,$5,$4 in ID.
    set_id(1'b1, 32'h200, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 32'd8, 3'b010, 1, 0, 1, 1, 0, 0);
    step();
    chk("lw_memtoreg", {31'd0, ex_memtoreg}, 32'd1);
    set_id(1'b1, 32'h204, 5'd5, 5'd4, 5'd6, 32'd11, 32'd3, 32'd0, 3'b110, 0, 1, 1, 0, 0, 0);
    #1;
    chk("lu_stall_hit", {31'd0, lu_stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
    chk("lu_stall_clear", {31'd0, lu_stall}, 32'd0);
    step();
    chk("sub_valid", {31'd0, ex_valid}, 32'd1);
    chk("sub_op", {29'd0, alu_op}, 32'b110);
    chk("sub_wreg", {27'd0, ex_writereg}, 32'd6);
    chk("sub_pc", ex_pc, 32'h204);

    // Stall holds for three cycles while ID changes; forwarding still tracks MEM.
    stall = 1'b1;
    set_id(1'b1, 32'h300, 5'd9, 5'd10, 5'd11, 32'd1, 32'd1, 32'd0, 3'b001, 0, 1, 0, 0, 1, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d_pc", c), ex_pc, 32'h204);
      chk($sformatf("stall%0d_op", c), {29'd0, alu_op}, 32'b110);
      chk($sformatf("stall%0d_wreg", c), {27'd0, ex_writereg}, 32'd6);
      chk($sformatf("stall%0d_ctl", c), {28'd0, ex_valid, ex_regwrite, ex_memwrite, ex_branch}, 32'b1100);
    end
    set_fwd(1'b1, 5'd5, 32'h77, 1'b0, 0, 0);
    #1;
    chk("stall_fwd_a", alu_a, 32'h77);
    chk("stall_fwd_sel", {30'd0, fwd_a_sel}, 32'b10);
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_ctl", {28'd0, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch}, 32'd0);
    chk("flush_pc", ex_pc, 32'd0);
    flush = 1'b0; stall = 1'b0;
    set_fwd(1'b0, 0, 0, 1'b0, 0, 0);

    // Asynchronous reset while stalled.
    step();
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_pc", ex_pc, 32'd0);
    chk("async_rst_op", {29'd0, alu_op}, 32'd0);
    chk("async_rst_ctl", {28'd0, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch}, 32'd0);
    step();
    rst = 1'b1;
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
